mul4_vec_scorer: RTL and testbench



---
 rtl/mul4_pkg.sv | 40 ++++
 rtl/popcount16.sv | 17 +
 rtl/mul4_vec_scorer.sv | 153 +++++++++++++++
 tb/tb_mul4_vec_scorer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul4_pkg.sv
// Shared constants, state encoding and helpers for the 2x2 vector multiplier scorer.
// Stimulus planes enumerate all 16 (a,b) pairs: lane i carries a=i[3:2], b=i[1:0].
// Golden planes hold the bits of the 4-bit product a*b in each lane.
package mul4_pkg;

  localparam int unsigned LANES   = 16;
  localparam int unsigned PLANES  = 4;
  localparam int unsigned PC_W    = 5;
  localparam int unsigned SCORE_W = 7;
  localparam int unsigned K_W     = 2;

  localparam logic [LANES-1:0] STIM_A1 = 16'hFF00;
  localparam logic [LANES-1:0] STIM_A0 = 16'hF0F0;
  localparam logic [LANES-1:0] STIM_B1 = 16'hCCCC;
  localparam logic [LANES-1:0] STIM_B0 = 16'hAAAA;

  localparam logic [LANES-1:0] GOLD_3 = 16'h8000;
  localparam logic [LANES-1:0] GOLD_2 = 16'h4C00;
  localparam logic [LANES-1:0] GOLD_1 = 16'h6AC0;
  localparam logic [LANES-1:0] GOLD_0 = 16'hA0A0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCORE = 2'd1,
    DONE  = 2'd2
  } scorer_state_t;

  // Golden plane for product bit k.
  function automatic logic [LANES-1:0] golden_plane(input logic [K_W-1:0] k);
    logic [LANES-1:0] g;
    case (k)
      2'd3:    g = GOLD_3;
      2'd2:    g = GOLD_2;
      2'd1:    g = GOLD_1;
      default: g = GOLD_0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/popcount16.sv
// Combinational population count of a 16-bit vector.
// Ports: vec (16-bit input), count_c (5-bit count, 0..16).
module popcount16
  import mul4_pkg::*;
(
  input  logic [LANES-1:0] vec,
  output logic [PC_W-1:0]  count_c
);

  always_comb begin
    count_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      count_c = count_c + PC_W'(vec[i]);
    end
  end

endmodule

// File: rtl/mul4_vec_scorer.sv
// Fitness scorer for bit-sliced 2x2 vector multiplier candidates.
// Drives constant exhaustive stimulus, accepts a candidate's four result planes,
// counts bits matching the golden product one plane per cycle, emits the score
// and tracks the best candidate seen since reset or clear.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   a1,a0,b1,b0              - constant stimulus planes
//   in_valid/in_ready/in_id  - candidate handshake and identifier
//   y3..y0                   - candidate result planes
//   out_valid/out_ready      - score handshake
//   out_id/out_score         - identifier and matching-bit count (0..64)
//   best_valid/score/id      - best tracker
//   clear_best               - clears the best tracker
module mul4_vec_scorer
  import mul4_pkg::*;
#(
  parameter int unsigned ID_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [LANES-1:0]     a1,
  output logic [LANES-1:0]     a0,
  output logic [LANES-1:0]     b1,
  output logic [LANES-1:0]     b0,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_W-1:0]      in_id,
  input  logic [LANES-1:0]     y3,
  input  logic [LANES-1:0]     y2,
  input  logic [LANES-1:0]     y1,
  input  logic [LANES-1:0]     y0,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_id,
  output logic [SCORE_W-1:0]   out_score,
  output logic                 best_valid,
  output logic [SCORE_W-1:0]   best_score,
  output logic [ID_W-1:0]      best_id,
  input  logic                 clear_best
);

  scorer_state_t state, state_nxt;

  logic [K_W-1:0]               k;
  logic [PLANES-1:0][LANES-1:0] y_q;
  logic [ID_W-1:0]              id_q;
  logic [SCORE_W-1:0]           acc;
  logic [SCORE_W-1:0]           acc_sum_c;
  logic [LANES-1:0]             match_c;
  logic [PC_W-1:0]              plane_pc_c;
  logic                         accept_c;
  logic                         handshake_c;
  logic                         last_plane_c;

  // Stimulus is wired constant, independent of state and reset.
  assign a1 = STIM_A1;
  assign a0 = STIM_A0;
  assign b1 = STIM_B1;
  assign b0 = STIM_B0;

  // Bits of the selected plane agreeing with the golden plane.
  assign match_c = ~(y_q[k] ^ golden_plane(k));

  popcount16 u_popcount (
    .vec     (match_c),
    .count_c (plane_pc_c)
  );

  // Max total is 4*16 = 64, so the 7-bit accumulator never wraps.
  assign acc_sum_c    = acc + SCORE_W'(plane_pc_c);
  assign last_plane_c = (k == K_W'(0));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt   = state;
    accept_c    = 1'b0;
    handshake_c = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c  = 1'b1;
          state_nxt = SCORE;
        end
      end
      SCORE: begin
        if (last_plane_c) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          handshake_c = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Candidate capture, serial accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      y_q       <= '0;
      id_q      <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_score <= '0;
      out_id    <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept_c) begin
        y_q  <= {y3, y2, y1, y0};
        id_q <= in_id;
        acc  <= '0;
        k    <= K_W'(3);
      end else if (state == SCORE) begin
        acc <= acc_sum_c;
        k   <= k - K_W'(1);
        if (last_plane_c) begin
          out_score <= acc_sum_c;
          out_id    <= id_q;
        end
      end
    end
  end

  // Best tracker: strict improvement wins, ties keep the earlier id.
  // A clear coinciding with a handshake still loads the handshaken result.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_valid <= 1'b0;
      best_score <= '0;
      best_id    <= '0;
    end else if (handshake_c &&
                 (clear_best || !best_valid || (out_score > best_score))) begin
      best_valid <= 1'b1;
      best_score <= out_score;
      best_id    <= out_id;
    end else if (clear_best) begin
      best_valid <= 1'b0;
      best_score <= '0;
      best_id    <= '0;
    end
  end

endmodule

// File: tb/tb_mul4_vec_scorer.sv
// Randomized self-checking bench for mul4_vec_scorer with a lane-level
// reference model of the 2x2 multiplier and of the best tracker.
module tb_mul4_vec_scorer;

  localparam int unsigned ID_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       a1, a0, b1, b0;
  logic              in_valid;
  logic              in_ready;
  logic [ID_W-1:0]   in_id;
  logic [15:0]       y3, y2, y1, y0;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_id;
  logic [6:0]        out_score;
  logic              best_valid;
  logic [6:0]        best_score;
  logic [ID_W-1:0]   best_id;
  logic              clear_best;

  int tests  = 0;
  int errors = 0;

  // Reference best tracker.
  bit          m_bv;
  int          m_bs;
  int          m_bi;
  logic [15:0] gold [4];

  mul4_vec_scorer #(.ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .a1         (a1),
    .a0         (a0),
    .b1         (b1),
    .b0         (b0),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_id      (in_id),
    .y3         (y3),
    .y2         (y2),
    .y1         (y1),
    .y0         (y0),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_score  (out_score),
    .best_valid (best_valid),
    .best_score (best_score),
    .best_id    (best_id),
    .clear_best (clear_best)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Product bit p of a*b in lane i, with a=i/4, b=i%4.
  function automatic bit prod_bit(input int i, input int p);
    int prod;
    prod = (i / 4) * (i % 4);
    return ((prod >> p) & 1) == 1;
  endfunction

  // Stimulus bit: a1 lane i is bit 1 of a=i/4, and so on.
  function automatic logic [15:0] stim_plane(input bit is_a, input int bitn);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      v[i] = is_a ? (((i / 4) >> bitn) & 1) == 1 : (((i % 4) >> bitn) & 1) == 1;
    end
    return v;
  endfunction

  function automatic int ref_score(input logic [15:0] p3, input logic [15:0] p2,
                                   input logic [15:0] p1, input logic [15:0] p0);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      if (p3[i] == prod_bit(i, 3)) s++;
      if (p2[i] == prod_bit(i, 2)) s++;
      if (p1[i] == prod_bit(i, 1)) s++;
      if (p0[i] == prod_bit(i, 0)) s++;
    end
    return s;
  endfunction

  task automatic check_best(input string tag);
    check({tag, "_bvalid"}, 32'(best_valid), 32'(m_bv));
    check({tag, "_bscore"}, 32'(best_score), 32'(m_bs));
    check({tag, "_bid"},    32'(best_id),    32'(m_bi));
  endtask

  // Present one candidate, check latency/score/id, apply backpressure, handshake.
  task automatic run_cand(input string tag, input int id,
                          input logic [15:0] p3, input logic [15:0] p2,
                          input logic [15:0] p1, input logic [15:0] p0,
                          input int hold, input bit clr);
    int n;
    int exp_s;
    exp_s = ref_score(p3, p2, p1, p0);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, 32'(n < 50), 32'd1);
    in_valid = 1'b1;
    in_id    = ID_W'(id);
    y3 = p3; y2 = p2; y1 = p1; y0 = p0;
    tick();
    in_valid = 1'b0;
    y3 = 16'h0; y2 = 16'h0; y1 = 16'h0; y0 = 16'h0;
    check({tag, "_inrdy_busy"}, 32'(in_ready), 32'd0);
    // Accept cycle is 0; out_valid shows in cycle 5, i.e. 4 edges later.
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd5);
    check({tag, "_score"},   32'(out_score), 32'(exp_s));
    check({tag, "_id"},      32'(out_id),    32'(id));
    for (int c = 0; c < hold; c++) begin
      // A competing request during DONE must be ignored.
      in_valid = 1'b1;
      in_id    = ID_W'(id + 1);
      tick();
      check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_bp_score"}, 32'(out_score), 32'(exp_s));
      check({tag, "_bp_id"},    32'(out_id),    32'(id));
      check({tag, "_bp_inrdy"}, 32'(in_ready),  32'd0);
    end
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clear_best = clr;
    tick();
    out_ready  = 1'b0;
    clear_best = 1'b0;
    if (clr || !m_bv || exp_s > m_bs) begin
      m_bv = 1'b1;
      m_bs = exp_s;
      m_bi = id;
    end
    check({tag, "_post_ovalid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_inrdy"},  32'(in_ready),  32'd1);
    check_best(tag);
  endtask

  initial begin
    logic [15:0] r3, r2, r1, r0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) gold[p][i] = prod_bit(i, p);
    end
    rst = 1'b1; in_valid = 1'b0; in_id = '0; out_ready = 1'b0; clear_best = 1'b0;
    y3 = 16'h0; y2 = 16'h0; y1 = 16'h0; y0 = 16'h0;
    m_bv = 1'b0; m_bs = 0; m_bi = 0;

    tick();
    tick();
    check("rst_inrdy",  32'(in_ready),   32'd0);
    check("rst_ovalid", 32'(out_valid),  32'd0);
    check("rst_oscore", 32'(out_score),  32'd0);
    check("rst_oid",    32'(out_id),     32'd0);
    check_best("rst");
    check("stim_a1", 32'(a1), 32'(stim_plane(1'b1, 1)));
    check("stim_a0", 32'(a0), 32'(stim_plane(1'b1, 0)));
    check("stim_b1", 32'(b1), 32'(stim_plane(1'b0, 1)));
    check("stim_b0", 32'(b0), 32'(stim_plane(1'b0, 0)));
    rst = 1'b0;
    tick();
    check("post_rst_inrdy", 32'(in_ready), 32'd1);

    run_cand("perfect", 5, gold[3], gold[2], gold[1], gold[0], 0, 1'b0);

    // Clear alone empties the tracker.
    clear_best = 1'b1;
    tick();
    clear_best = 1'b0;
    m_bv = 1'b0; m_bs = 0; m_bi = 0;
    check_best("clear");

    run_cand("zero_id1", 1, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1'b0);
    run_cand("zero_id2", 2, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1'b0);
    run_cand("ones",     7, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_cand("perf_id3", 3, gold[3], gold[2], gold[1], gold[0], 0, 1'b0);
    run_cand("backpres", 9, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 10, 1'b0);
    run_cand("clr_hs",   4, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1'b1);

    // Reset during SCORE cycle 2 abandons the candidate.
    in_valid = 1'b1; in_id = ID_W'(11);
    y3 = gold[3]; y2 = gold[2]; y1 = gold[1]; y0 = gold[0];
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_bv = 1'b0; m_bs = 0; m_bi = 0;
    check("midrst_ovalid", 32'(out_valid), 32'd0);
    check_best("midrst");
    tick();
    check("midrst_inrdy",   32'(in_ready),  32'd1);
    check("midrst_ovalid2", 32'(out_valid), 32'd0);
    run_cand("after_rst", 12, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1'b0);

    // Random candidates: sparse corruptions of the golden planes or raw noise.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        r3 = 16'($urandom); r2 = 16'($urandom); r1 = 16'($urandom); r0 = 16'($urandom);
      end else begin
        r3 = gold[3] ^ 16'($urandom & $urandom & $urandom);
        r2 = gold[2] ^ 16'($urandom & $urandom & $urandom);
        r1 = gold[1] ^ 16'($urandom & $urandom & $urandom);
        r0 = gold[0] ^ 16'($urandom & $urandom & $urandom);
      end
      run_cand("rand", int'($urandom_range(0, 255)), r3, r2, r1, r0,
               int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    check("end_stim_a1", 32'(a1), 32'(stim_plane(1'b1, 1)));
    check("end_stim_b0", 32'(b0), 32'(stim_plane(1'b0, 0)));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
